// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter that owns the single write port of a shared WIDTH-bit register.
// Optional feature: define ARB_LOCK_EN to add the lock port and bounded hold-grant.

module dff_write_arbiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             req,
  input  logic             gnt,
  input  logic [WIDTH-1:0] wdata,
  output logic             elig,
  output logic [WIDTH-1:0] wsel
);
  // The lane currently holding the grant drops out of the next scan.
  assign elig = req & ~gnt;
  assign wsel = gnt ? wdata : '0;
endmodule

module dff_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 4,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wdata,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [CNT_W-1:0]         wr_count
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                        state, state_nx;
  logic [IDW-1:0]                g_idx, g_nx, ptr, ptr_nx, base, win;
  logic [NREQ-1:0]               gnt_nx, elig;
  logic [NREQ-1:0][WIDTH-1:0]    wsel;
  logic [WIDTH-1:0]              gdata;
  logic                          found, wr_done, hold_keep;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    dff_write_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .req   (req[i]),
      .gnt   (gnt[i]),
      .wdata (wdata[i*WIDTH +: WIDTH]),
      .elig  (elig[i]),
      .wsel  (wsel[i])
    );
  end

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NREQ; i++) gdata |= wsel[i];
  end

  // While granting, the current owner is already the new pointer, so it ends up last.
  assign base = (state == GRANT) ? g_idx : ptr;

  always_comb begin : scan
    int t;
    t     = 0;
    win   = base;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      t = (int'(base) + k) % NREQ;
      if (!found && elig[IDW'(t)]) begin
        found = 1'b1;
        win   = IDW'(t);
      end
    end
  end

`ifdef ARB_LOCK_EN
  localparam int HW = $clog2(LOCK_MAX + 1);
  logic [HW-1:0] hold, hold_nx;

  // hold counts grants to g_idx in the current run, including the one in flight.
  assign hold_keep = (state == GRANT) && lock[g_idx] && (hold < HW'(LOCK_MAX));

  always_comb begin
    hold_nx = '0;
    if (state_nx == GRANT) hold_nx = hold_keep ? hold + 1'b1 : HW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold <= '0;
    else       hold <= hold_nx;
  end
`else
  assign hold_keep = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = '0;
    g_nx     = g_idx;
    ptr_nx   = ptr;
    wr_done  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx    = GRANT;
          gnt_nx[win] = 1'b1;
          g_nx        = win;
        end
      end
      GRANT: begin
        wr_done = 1'b1;
        ptr_nx  = g_idx;
        if (hold_keep) begin
          gnt_nx = gnt;
        end else if (found) begin
          gnt_nx[win] = 1'b1;
          g_nx        = win;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      g_idx    <= '0;
      ptr      <= IDW'(NREQ - 1);
      q        <= '0;
      q_valid  <= 1'b0;
      owner    <= '0;
      wr_count <= '0;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      g_idx   <= g_nx;
      ptr     <= ptr_nx;
      q_valid <= wr_done;
      if (wr_done) begin
        q     <= gdata;
        owner <= g_idx;
        if (wr_count != '1) wr_count <= wr_count + 1'b1;
      end
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Scoreboard bench for dff_write_arbiter (NREQ=4, WIDTH=8, CNT_W=4 so saturation is reachable).
module tb_dff_write_arbiter;
  logic        clk, reset;
  logic [3:0]  req;
  logic [31:0] wdata;
`ifdef ARB_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  wr_count;

  int n_chk = 0;
  int n_err = 0;

  dff_write_arbiter #(.NREQ(4), .WIDTH(8), .LOCK_MAX(4), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wdata    (wdata),
`ifdef ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .q        (q),
    .q_valid  (q_valid),
    .owner    (owner),
    .busy     (busy),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected writes go to the scoreboard at the edge that completes them.
  typedef struct packed {logic [1:0] idx; logic [7:0] d;} wr_t;
  wr_t        sb[$];
  bit         m_st;
  logic [1:0] m_g, m_ptr;
  logic [3:0] m_cnt;
  int         m_hold;
  logic [3:0] m_gnt;
  assign m_gnt = m_st ? (4'b0001 << m_g) : 4'b0000;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= 1'b0; m_g <= 2'd0; m_ptr <= 2'd3; m_hold <= 0; m_cnt <= 4'd0;
      sb.delete();
    end else begin : mdl
      logic [3:0] cand;
      logic [1:0] from, ix;
      int         nx;
      bit         keep;
      cand = req; keep = 1'b0; from = m_ptr; nx = -1; ix = 2'd0;
      if (m_st) begin
        sb.push_back('{m_g, wdata[m_g*8 +: 8]});
        m_cnt <= (m_cnt == 4'hF) ? 4'hF : m_cnt + 4'd1;
        m_ptr <= m_g;
        from  = m_g;
        cand[m_g] = 1'b0;
`ifdef ARB_LOCK_EN
        keep = lock[m_g] && (m_hold < 4);
`endif
      end
      if (keep) begin
        m_hold <= m_hold + 1;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          ix = from + 2'(k);
          if (nx < 0 && cand[ix]) nx = int'(ix);
        end
        if (nx >= 0) begin m_st <= 1'b1; m_g <= 2'(nx); m_hold <= 1; end
        else         begin m_st <= 1'b0; m_hold <= 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt", gnt, m_gnt);
      chk("busy", busy, m_st);
      chk("wr_count", wr_count, m_cnt);
      if (q_valid) begin
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin : pop
          wr_t e;
          e = sb.pop_front();
          chk("q", q, e.d);
          chk("owner", owner, e.idx);
        end
      end else begin
        chk("sb_size", sb.size(), 0);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    req = 4'b0000;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : stim
    bit ok;
    int hits;
    reset = 1'b1; req = 4'hF; wdata = '0;
`ifdef ARB_LOCK_EN
    lock = 4'b0000;
`endif
    // Reset state with every requester asserting
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_q", q, 8'h00);
    chk("rst_qv", q_valid, 1'b0);
    chk("rst_cnt", wr_count, 4'h0);
    chk("rst_busy", busy, 1'b0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("first_gnt", gnt, 4'b0001);
    #1 idle_cycles(3);

    // Single requester, latency and count
    do_reset();
    wdata = 32'h00A5_0000; req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0100);
    #1 req = 4'b0000;
    @(negedge clk);
    chk("single_q", q, 8'hA5);
    chk("single_owner", owner, 2'd2);
    chk("single_qv", q_valid, 1'b1);
    chk("single_cnt", wr_count, 4'd1);
    @(negedge clk);
    chk("single_qv_pulse", q_valid, 1'b0);
    #1;

    // Round-robin with all requesters held
    do_reset();
    wdata = 32'h1312_1110; req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_gnt", gnt, 4'b0001 << (k % 4));
      if (k >= 1) chk("rr_q", q, 8'h10 + 8'((k - 1) % 4));
    end

    // Reset while requester 1 holds the grant
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (gnt == 4'b0010) ok = 1'b1;
    end
    chk("wait_gnt1", ok, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("mid_gnt", gnt, 4'b0000);
    chk("mid_q", q, 8'h00);
    chk("mid_cnt", wr_count, 4'h0);
    chk("mid_qv", q_valid, 1'b0);
    @(negedge clk);
    chk("mid_qv_after", q_valid, 1'b0);
    #1 reset = 1'b0;

    // Counter saturation: writes every cycle well past 15
    wdata = $urandom; req = 4'hF;
    repeat (22) @(negedge clk);
    chk("sat_cnt", wr_count, 4'hF);
    #1 idle_cycles(3);

    // A lone continuous requester writes every other cycle
    req = 4'b0100; hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt != 4'b0000) hits++;
    end
    chk("single_rate", hits, 4);
    #1 idle_cycles(3);

`ifdef ARB_LOCK_EN
    // Lock holds requester 1 for LOCK_MAX grants, then releases
    do_reset();
    lock = 4'b0010; req = 4'b0011; wdata = 32'h0000_BB0A;
    @(negedge clk);
    chk("lock_g0", gnt, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lock_hold", gnt, 4'b0010);
    end
    @(negedge clk);
    chk("lock_release", gnt, 4'b0001);
    #1 lock = 4'b0000;
    idle_cycles(3);
`endif

    // Random traffic against the scoreboard
    do_reset();
    repeat (300) begin
      req   = 4'($urandom);
      wdata = $urandom;
`ifdef ARB_LOCK_EN
      lock  = 4'($urandom);
`endif
      @(negedge clk); #1;
    end
    idle_cycles(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
